pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Detects load-use hazards
//  (IF/ID vs ID/EX), flushes IF/ID on a taken branch resolved in ID, and freezes the whole
//  pipeline during multi-cycle data-memory accesses via a start/ready handshake.
//  Also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.
// PARAMETERS
//  TIMEOUT   16  max MEM_WAIT cycles without DMem_ready_i before entering MEM_ERR (>=2)
//  CNT_W     16  width of performance counters
//  REG_AW    5   register-address width
// PORTS
//  clk_i            in   1       clock; all state updates on rising edge
//  rst_i            in   1       reset, synchronous, active-high
//  IDEX_MemRead_i   in   1       instruction in EX is a load
//  IDEX_RdAddr_i    in   REG_AW  destination register of instruction in EX
//  IFID_RsAddr1_i   in   REG_AW  rs1 of instruction in ID
//  IFID_RsAddr2_i   in   REG_AW  rs2 of instruction in ID
//  Branch_taken_i   in   1       branch in ID resolved taken this cycle
//  DMem_req_i       in   1       instruction in MEM performs a load or store
//  DMem_ready_i     in   1       data memory completes the outstanding access
//  PC_Write_o       out  1       1 = PC may update
//  IFID_Write_o     out  1       1 = IF/ID register may load
//  IFID_Flush_o     out  1       1 = IF/ID loaded with NOP
//  IDEX_Bubble_o    out  1       1 = ID/EX control fields zeroed
//  Pipe_Stall_o     out  1       1 = ID/EX, EX/MEM, MEM/WB hold their contents
//  DMem_start_o     out  1       one-cycle pulse launching a data-memory access
//  Mem_err_o        out  1       sticky: access exceeded TIMEOUT
//  Stall_cnt_o      out  CNT_W   cycles with PC_Write_o=0 (saturating)
//  Flush_cnt_o      out  CNT_W   cycles with IFID_Flush_o=1 (saturating)
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): state<=RUN, wait_cnt<=0, counters<=0, Mem_err_o<=0.
//    While rst_i=1 outputs forced: PC_Write_o=0, IFID_Write_o=0, IFID_Flush_o=1,
//    IDEX_Bubble_o=1, Pipe_Stall_o=0, DMem_start_o=0. Reset mid-access abandons it.
//  - Control outputs are combinational from state + inputs (zero latency); counters, state registered.
//  - States: RUN, MEM_WAIT, MEM_ERR.
//  - RUN, DMem_req_i=1: DMem_start_o=1, Pipe_Stall_o=1, PC_Write_o=IFID_Write_o=0,
//    no flush/bubble; next MEM_WAIT, wait_cnt<=0. DMem_ready_i ignored in RUN (min latency 1).
//  - MEM_WAIT: DMem_ready_i=0 -> full freeze as above (DMem_start_o=0), wait_cnt++;
//    wait_cnt==TIMEOUT-1 with no ready -> MEM_ERR, Mem_err_o<=1.
//    DMem_ready_i=1 -> freeze released this cycle, hazard/branch rules below apply, next RUN.
//  - MEM_ERR: permanent full freeze until rst_i; Mem_err_o=1.
//  - Load-use (RUN, no DMem_req_i, or MEM_WAIT release cycle): IDEX_MemRead_i=1 and
//    IDEX_RdAddr_i!=0 and equals rs1 or rs2 -> PC_Write_o=0, IFID_Write_o=0,
//    IDEX_Bubble_o=1. rs2 compared always (conservative).
//  - Branch_taken_i=1 with no load-use and no freeze -> IFID_Flush_o=1, PC_Write_o=1.
//  - Priority: memory freeze > load-use (branch operands not ready, flush suppressed) > branch.
//  - Default (no event): PC_Write_o=IFID_Write_o=1, others 0.
//  - Counters increment once per non-reset cycle on condition, saturate at 2^CNT_W-1.
// STRUCTURE
//  - Shared package riscv_ctrl_pkg: state enum (RUN/MEM_WAIT/MEM_ERR), REG_AW, x0 address constant.
//  - One sub-module: sat_counter (width param, inc enable, sync clear), instantiated twice.
// TESTING
//  1. Load x5 in EX, ID reads rs1=x5 -> one cycle PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1; Stall_cnt_o=1.
//  2. Load x0 in EX, ID rs1=x0 -> no stall; Branch_taken_i=1 -> IFID_Flush_o=1 one cycle, Flush_cnt_o=1.
//  3. DMem_req_i=1, ready after 3 cycles -> DMem_start_o one pulse, Pipe_Stall_o=1 for exactly 3 cycles.
//  4. Load-use + Branch_taken_i same cycle -> bubble asserted, IFID_Flush_o=0; next cycle flush.
//  5. DMem_req_i=1, ready never, TIMEOUT=16 -> MEM_ERR after 16 cycles, Mem_err_o=1, freeze held; rst_i clears.
//  6. rst_i asserted in MEM_WAIT -> next cycle RUN, counters 0, DMem_ready_i then ignored.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline control slice.
package riscv_ctrl_pkg;

  localparam int RV_REG_AW = 5;
  localparam logic [RV_REG_AW-1:0] X0_ADDR = '0;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_e;

  // Bundle of pipeline control strobes driven by the sequencer.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_stall;
    logic dmem_start;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pipe_stall: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_RST    = '{ifid_flush: 1'b1, idex_bubble: 1'b1, default: 1'b0};

  // Hazard/branch resolution once the pipeline is not frozen: a load-use
  // hazard wins over a taken branch, since the branch operands are not ready.
  function automatic ctrl_t hazard_ctrl(input logic load_use, input logic br_taken);
    ctrl_t c;
    c = CTRL_RUN;
    if (load_use) begin
      c.pc_write    = 1'b0;
      c.ifid_write  = 1'b0;
      c.idex_bubble = 1'b1;
    end else if (br_taken) begin
      c.ifid_flush  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  // Clear dominates; otherwise count up and hold at all-ones.
  always_ff @(posedge clk_i) begin
    if (clr_i)                      cnt_o <= '0;
    else if (inc_i && cnt_o != '1)  cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes, data-memory freeze with timeout, and saturating perf counters.
module pipeline_hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16,
  parameter int REG_AW  = RV_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RdAddr_i,
  input  logic [REG_AW-1:0] IFID_RsAddr1_i,
  input  logic [REG_AW-1:0] IFID_RsAddr2_i,
  input  logic              Branch_taken_i,
  input  logic              DMem_req_i,
  input  logic              DMem_ready_i,
  output logic              PC_Write_o,
  output logic              IFID_Write_o,
  output logic              IFID_Flush_o,
  output logic              IDEX_Bubble_o,
  output logic              Pipe_Stall_o,
  output logic              DMem_start_o,
  output logic              Mem_err_o,
  output logic [CNT_W-1:0]  Stall_cnt_o,
  output logic [CNT_W-1:0]  Flush_cnt_o
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_e          state;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_err;
  logic            load_use;
  ctrl_t           ctl;

  // rs2 is compared unconditionally: a false stall is cheaper than decoding
  // whether the instruction in ID actually reads rs2.
  assign load_use = IDEX_MemRead_i && (IDEX_RdAddr_i != REG_AW'(X0_ADDR)) &&
                    ((IDEX_RdAddr_i == IFID_RsAddr1_i) || (IDEX_RdAddr_i == IFID_RsAddr2_i));

  // Zero-latency control decode: reset > memory freeze > load-use > branch.
  always_comb begin
    ctl = CTRL_RUN;
    if (rst_i) begin
      ctl = CTRL_RST;
    end else begin
      case (state)
        RUN: begin
          if (DMem_req_i) begin
            ctl            = CTRL_FREEZE;
            ctl.dmem_start = 1'b1;
          end else begin
            ctl = hazard_ctrl(load_use, Branch_taken_i);
          end
        end
        MEM_WAIT: begin
          if (DMem_ready_i) ctl = hazard_ctrl(load_use, Branch_taken_i);
          else              ctl = CTRL_FREEZE;
        end
        default: ctl = CTRL_FREEZE;
      endcase
    end
  end

  assign PC_Write_o    = ctl.pc_write;
  assign IFID_Write_o  = ctl.ifid_write;
  assign IFID_Flush_o  = ctl.ifid_flush;
  assign IDEX_Bubble_o = ctl.idex_bubble;
  assign Pipe_Stall_o  = ctl.pipe_stall;
  assign DMem_start_o  = ctl.dmem_start;
  assign Mem_err_o     = mem_err;

  // Access sequencer; ready is only honoured from MEM_WAIT, so the minimum
  // access latency is one cycle. MEM_ERR is left only through reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (DMem_req_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (DMem_ready_i) begin
            state <= RUN;
          end else if (wait_cnt == WC_LAST) begin
            state   <= MEM_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        MEM_ERR: mem_err <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (!ctl.pc_write),
    .cnt_o (Stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (ctl.ifid_flush),
    .cnt_o (Flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random
// traffic, each cycle compared against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RdAddr_i;
  logic [4:0]       IFID_RsAddr1_i;
  logic [4:0]       IFID_RsAddr2_i;
  logic             Branch_taken_i;
  logic             DMem_req_i;
  logic             DMem_ready_i;
  logic             PC_Write_o;
  logic             IFID_Write_o;
  logic             IFID_Flush_o;
  logic             IDEX_Bubble_o;
  logic             Pipe_Stall_o;
  logic             DMem_start_o;
  logic             Mem_err_o;
  logic [CNT_W-1:0] Stall_cnt_o;
  logic [CNT_W-1:0] Flush_cnt_o;

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .REG_AW(5)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RdAddr_i  (IDEX_RdAddr_i),
    .IFID_RsAddr1_i (IFID_RsAddr1_i),
    .IFID_RsAddr2_i (IFID_RsAddr2_i),
    .Branch_taken_i (Branch_taken_i),
    .DMem_req_i     (DMem_req_i),
    .DMem_ready_i   (DMem_ready_i),
    .PC_Write_o     (PC_Write_o),
    .IFID_Write_o   (IFID_Write_o),
    .IFID_Flush_o   (IFID_Flush_o),
    .IDEX_Bubble_o  (IDEX_Bubble_o),
    .Pipe_Stall_o   (Pipe_Stall_o),
    .DMem_start_o   (DMem_start_o),
    .Mem_err_o      (Mem_err_o),
    .Stall_cnt_o    (Stall_cnt_o),
    .Flush_cnt_o    (Flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: "busy" = an access is outstanding, "broken" = timed out,
  // "idle_waits" = cycles spent waiting without a ready.
  bit m_busy, m_broken;
  int m_idle_waits;
  int m_stall, m_flush;

  // Observed-output tallies used by the directed scenarios.
  int n_stall_seen, n_start_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare at mid-cycle, advance the model.
  task automatic step(input bit rst, input bit mrd, input int rd, input int rs1, input int rs2,
                      input bit br, input bit req, input bit rdy);
    bit pcw, ifw, fl, bub, ps, st, freeze, lu;
    rst_i = rst; IDEX_MemRead_i = mrd; IDEX_RdAddr_i = 5'(rd);
    IFID_RsAddr1_i = 5'(rs1); IFID_RsAddr2_i = 5'(rs2);
    Branch_taken_i = br; DMem_req_i = req; DMem_ready_i = rdy;
    #4;
    freeze = 0; st = 0;
    if (rst) begin
      pcw = 0; ifw = 0; fl = 1; bub = 1; ps = 0;
    end else begin
      if (m_broken)               freeze = 1;
      else if (!m_busy && req)  begin freeze = 1; st = 1; end
      else if (m_busy && !rdy)    freeze = 1;
      lu = mrd && rd != 0 && (rd == rs1 || rd == rs2);
      if (freeze) begin
        pcw = 0; ifw = 0; fl = 0; bub = 0; ps = 1;
      end else begin
        pcw = !lu; ifw = !lu; bub = lu; fl = br && !lu; ps = 0;
      end
    end
    chk("ctrl{pcw,ifw,flush,bubble,stall,start}",
        {26'd0, PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Pipe_Stall_o, DMem_start_o},
        {26'd0, pcw, ifw, fl, bub, ps, st});
    chk("stall_cnt", 32'(Stall_cnt_o), 32'(m_stall));
    chk("flush_cnt", 32'(Flush_cnt_o), 32'(m_flush));
    chk("mem_err",   32'(Mem_err_o),   32'(m_broken));
    n_stall_seen += int'(Pipe_Stall_o);
    n_start_seen += int'(DMem_start_o);
    @(posedge clk_i);
    if (rst) begin
      m_busy = 0; m_broken = 0; m_idle_waits = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!pcw && m_stall < CNT_MAX) m_stall++;
      if (fl && m_flush < CNT_MAX)   m_flush++;
      if (!m_broken) begin
        if (!m_busy) begin
          if (req) begin m_busy = 1; m_idle_waits = 0; end
        end else if (rdy) begin
          m_busy = 0;
        end else begin
          m_idle_waits++;
          if (m_idle_waits == TIMEOUT) begin m_broken = 1; m_busy = 0; end
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_busy = 0; m_broken = 0; m_idle_waits = 0; m_stall = 0; m_flush = 0;
    n_stall_seen = 0; n_start_seen = 0;
    rst_i = 1; IDEX_MemRead_i = 0; IDEX_RdAddr_i = 0; IFID_RsAddr1_i = 0; IFID_RsAddr2_i = 0;
    Branch_taken_i = 0; DMem_req_i = 0; DMem_ready_i = 0;
    @(posedge clk_i); #1;

    // Reset: forced outputs, counters cleared.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 3, 0, 1, 1, 1);
    idle();

    // Load x5 in EX, ID reads x5: one stall cycle.
    step(0, 1, 5, 5, 0, 0, 0, 0);
    idle();
    chk("t1_stall_cnt", 32'(Stall_cnt_o), 32'd1);

    // Load x0 never hazards; then a taken branch flushes once.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    chk("t2_flush_cnt", 32'(Flush_cnt_o), 32'd1);
    chk("t2_stall_cnt", 32'(Stall_cnt_o), 32'd1);

    // Access with ready on the fourth cycle: three frozen cycles, one start.
    n_stall_seen = 0; n_start_seen = 0;
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t3_stall_cycles", 32'(n_stall_seen), 32'd3);
    chk("t3_start_pulses", 32'(n_start_seen), 32'd1);

    // Load-use on rs2 with a taken branch: bubble first, flush next cycle.
    step(0, 1, 7, 1, 7, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t4_flush_cnt", 32'(Flush_cnt_o), 32'd2);

    // Ready never comes: error after TIMEOUT waiting cycles, freeze sticks.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_mem_err", 32'(Mem_err_o), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 4, 4, 0, 1, 0, 1);
    chk("t5_frozen", 32'(Pipe_Stall_o), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_err_cleared", 32'(Mem_err_o), 32'd0);

    // Reset mid-access abandons it; a later ready is ignored.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    chk("t6_not_frozen", 32'(Pipe_Stall_o), 32'd0);

    // Saturation of the stall counter.
    for (int i = 0; i < CNT_MAX + 4; i++) step(0, 1, 9, 0, 9, 0, 0, 0);
    chk("sat_stall_cnt", 32'(Stall_cnt_o), 32'(CNT_MAX));

    // Random traffic against the model.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(59) == 0), ($urandom_range(1) == 1), int'($urandom_range(3)),
           int'($urandom_range(3)), int'($urandom_range(3)), ($urandom_range(3) == 0),
           ($urandom_range(5) == 0), ($urandom_range(2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
